// File: rtl/uart_cfg_if.sv
// Bus-side bundle for uart_cfg: runtime configuration, transmit handshake, receive status.
// Combinational bundle, no latency of its own.
// Transmit side uses tx_valid/tx_ready; the receive side has no backpressure (pulses only).
// Ports: master = register block (drives config and tx request), slave = the UART.
interface uart_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 two_stop;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_busy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output baud_div, parity_en, parity_odd, two_stop, tx_valid, tx_data,
    input  tx_ready, tx_busy, rx_valid, rx_data, rx_busy, parity_err, frame_err, break_det
  );

  modport slave (
    input  baud_div, parity_en, parity_odd, two_stop, tx_valid, tx_data,
    output tx_ready, tx_busy, rx_valid, rx_data, rx_busy, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: oversampling baud dividers, optional parity, 1/2 stop bits.
// TX: tx drops the cycle after acceptance; RX status pulses one cycle after the stop sample.
// TX backpressure via tx_ready (IDLE only); RX has none, a new word overwrites rx_data.
// Ports: clk, rst_n (async, active low), bus (uart_cfg_if.slave), tx (serial out), rx (serial in).
// Optional: define UART_BREAK_DETECT_EN to report all-zero frames on break_det.
module uart_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_cfg_if.slave bus,
  output logic      tx,
  input  logic      rx
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  // A divisor of 0 behaves as 1; the register holds divisor-1 as the reload value.
  logic [DIV_WIDTH-1:0] div_rld;
  assign div_rld = (bus.baud_div == '0) ? '0 : bus.baud_div - DIV_WIDTH'(1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  tx_state_t tx_st, tx_nx;

  logic [DIV_WIDTH-1:0] tx_div_cnt, tx_div_rld;
  logic [OSW-1:0]       tx_os;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par_en, tx_two, tx_par_bit, tx_q;
  logic                 tx_acc, tx_tick, tx_bend;

  assign tx_acc  = bus.tx_valid && (tx_st == TX_IDLE);
  assign tx_tick = (tx_st != TX_IDLE) && (tx_div_cnt == '0);
  assign tx_bend = tx_tick && (tx_os == OS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_st <= TX_IDLE;
    else        tx_st <= tx_nx;
  end

  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      TX_IDLE:  if (bus.tx_valid) tx_nx = TX_START;
      TX_START: if (tx_bend) tx_nx = TX_DATA;
      TX_DATA:  if (tx_bend && tx_bit == BIT_LAST) tx_nx = tx_par_en ? TX_PAR : TX_STOP;
      TX_PAR:   if (tx_bend) tx_nx = TX_STOP;
      // tx_bit counts stop bits here: 0 for the first, 1 for the second
      TX_STOP:  if (tx_bend && tx_bit == BW'(tx_two)) tx_nx = TX_IDLE;
      default:  tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_div_cnt <= '0;
      tx_div_rld <= '0;
      tx_os      <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_par_en  <= 1'b0;
      tx_two     <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_acc) begin
      tx_div_cnt <= div_rld;
      tx_div_rld <= div_rld;
      tx_os      <= '0;
      tx_bit     <= '0;
      tx_sh      <= bus.tx_data;
      tx_par_en  <= bus.parity_en;
      tx_two     <= bus.two_stop;
      tx_par_bit <= (^bus.tx_data) ^ bus.parity_odd;
      tx_q       <= 1'b0;
    end else if (tx_st != TX_IDLE) begin
      tx_div_cnt <= tx_tick ? tx_div_rld : tx_div_cnt - DIV_WIDTH'(1);
      if (tx_tick) tx_os <= tx_bend ? '0 : tx_os + OSW'(1);
      // the line value for the next bit is registered as the current bit ends
      if (tx_bend) begin
        case (tx_nx)
          TX_DATA: begin
            if (tx_st == TX_DATA) begin
              tx_sh  <= tx_sh >> 1;
              tx_q   <= tx_sh[1];
              tx_bit <= tx_bit + BW'(1);
            end else begin
              tx_q <= tx_sh[0];
            end
          end
          TX_PAR:  tx_q <= tx_par_bit;
          TX_STOP: begin
            tx_q   <= 1'b1;
            tx_bit <= (tx_st == TX_STOP) ? tx_bit + BW'(1) : '0;
          end
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end

  assign tx           = tx_q;
  assign bus.tx_ready = (tx_st == TX_IDLE);
  assign bus.tx_busy  = (tx_st != TX_IDLE);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t rx_st, rx_nx;

  logic                 rx_s1, rx_s2, rx_prev;
  logic [DIV_WIDTH-1:0] rx_div_cnt, rx_div_rld;
  logic [OSW-1:0]       rx_os;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh, rx_dat_q;
  logic                 rx_par_en, rx_par_odd, rx_pbit;
  logic                 rx_vld_q, perr_q, ferr_q;
  logic                 rx_edge, rx_tick, rx_half, rx_samp, par_ok, rx_brk;

  assign rx_edge = rx_prev && !rx_s2;
  assign rx_tick = (rx_st != RX_IDLE) && (rx_st != RX_WAIT) && (rx_div_cnt == '0);
  assign rx_half = rx_tick && (rx_st == RX_START) && (rx_os == OS_HALF);
  assign rx_samp = rx_tick && (rx_st != RX_START) && (rx_os == OS_LAST);
  assign par_ok  = !rx_par_en || (((^rx_sh) ^ rx_pbit ^ rx_par_odd) == 1'b0);

`ifdef UART_BREAK_DETECT_EN
  logic brk_q;
  assign rx_brk        = !rx_s2 && (rx_sh == '0) && !(rx_par_en && rx_pbit);
  assign bus.break_det = brk_q;
`else
  assign rx_brk        = 1'b0;
  assign bus.break_det = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_st <= RX_IDLE;
    else        rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:  if (rx_edge) rx_nx = RX_START;
      RX_START: if (rx_half) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_samp && rx_bit == BIT_LAST) rx_nx = rx_par_en ? RX_PAR : RX_STOP;
      RX_PAR:   if (rx_samp) rx_nx = RX_STOP;
      // a low stop bit parks the receiver until the line idles, so a held-low line cannot retrigger
      RX_STOP:  if (rx_samp) rx_nx = rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s2) rx_nx = RX_IDLE;
      default:  rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_div_cnt <= '0;
      rx_div_rld <= '0;
      rx_os      <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_dat_q   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_pbit    <= 1'b0;
      rx_vld_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_vld_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      brk_q    <= 1'b0;
`endif
      if (rx_st == RX_IDLE && rx_edge) begin
        rx_div_cnt <= div_rld;
        rx_div_rld <= div_rld;
        rx_os      <= '0;
        rx_bit     <= '0;
        rx_pbit    <= 1'b0;
        rx_par_en  <= bus.parity_en;
        rx_par_odd <= bus.parity_odd;
      end else if (rx_st != RX_IDLE && rx_st != RX_WAIT) begin
        rx_div_cnt <= rx_tick ? rx_div_rld : rx_div_cnt - DIV_WIDTH'(1);
        // realigning at mid start bit puts every later sample at mid-bit
        if (rx_tick) rx_os <= (rx_half || rx_samp) ? '0 : rx_os + OSW'(1);
        if (rx_samp) begin
          case (rx_st)
            RX_DATA: begin
              rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
              rx_bit <= rx_bit + BW'(1);
            end
            RX_PAR:  rx_pbit <= rx_s2;
            RX_STOP: begin
              if (rx_brk) begin
`ifdef UART_BREAK_DETECT_EN
                brk_q <= 1'b1;
`endif
              end else begin
                rx_dat_q <= rx_sh;
                ferr_q   <= !rx_s2;
                perr_q   <= !par_ok;
                rx_vld_q <= rx_s2 && par_ok;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.rx_valid   = rx_vld_q;
  assign bus.rx_data    = rx_dat_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = (rx_st != RX_IDLE);
endmodule
